simd_loop_sequencer: RTL and testbench

- Sits directly upstream of the SIMD iterator stage. Takes decoded 32-bit SIMD instructions over a valid/ready handshake and drives the iterator's instruction fields plus `in_loop`.
- Ordinary instructions pass straight through.
- A LOOP_CONFIG instruction makes the block capture the next N instructions into a body buffer. It then replays that body a programmed number of times, back-to-back, with `in_loop` asserted so the iterators apply base+stride updates.

---
 rtl/simd_loop_sequencer.sv | 172 +++++++++++++++++
 tb/tb_simd_loop_sequencer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/simd_loop_sequencer.sv
// Loop sequencer in front of the SIMD iterators: forwards ordinary instructions,
// captures a LOOP_CONFIG body and replays it back-to-back with in_loop asserted.
module simd_loop_sequencer #(
   parameter int OPCODE_BITS      = 4,
   parameter int FUNCTION_BITS    = 4,
   parameter int NS_ID_BITS       = 3,
   parameter int NS_INDEX_ID_BITS = 5,
   parameter int INST_WIDTH       = OPCODE_BITS + FUNCTION_BITS + 3*(NS_ID_BITS + NS_INDEX_ID_BITS),
   parameter int BODY_DEPTH       = 2**NS_INDEX_ID_BITS,
   parameter int ITER_BITS        = 2*(NS_ID_BITS + NS_INDEX_ID_BITS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [INST_WIDTH-1:0]       inst_in,
   input  logic                        inst_valid,
   output logic                        inst_ready,
   output logic [OPCODE_BITS-1:0]      opcode,
   output logic [FUNCTION_BITS-1:0]    fn,
   output logic [NS_ID_BITS-1:0]       dest_ns_id,
   output logic [NS_INDEX_ID_BITS-1:0] dest_ns_index_id,
   output logic [NS_ID_BITS-1:0]       src1_ns_id,
   output logic [NS_INDEX_ID_BITS-1:0] src1_ns_index_id,
   output logic [NS_ID_BITS-1:0]       src2_ns_id,
   output logic [NS_INDEX_ID_BITS-1:0] src2_ns_index_id,
   output logic                        in_loop,
   output logic                        out_valid,
   output logic                        loop_done,
   output logic                        busy,
   output logic                        loop_err
);

   localparam int FIELD_BITS   = NS_ID_BITS + NS_INDEX_ID_BITS;
   localparam int SRC2_IDX_LSB = 0;
   localparam int SRC2_ID_LSB  = NS_INDEX_ID_BITS;
   localparam int SRC1_IDX_LSB = FIELD_BITS;
   localparam int SRC1_ID_LSB  = FIELD_BITS + NS_INDEX_ID_BITS;
   localparam int DEST_IDX_LSB = 2*FIELD_BITS;
   localparam int DEST_ID_LSB  = 2*FIELD_BITS + NS_INDEX_ID_BITS;
   localparam int FN_LSB       = 3*FIELD_BITS;
   localparam int OP_LSB       = 3*FIELD_BITS + FUNCTION_BITS;
   localparam int PTR_BITS     = NS_INDEX_ID_BITS;

   localparam logic [OPCODE_BITS-1:0]   OP_NOP  = '1;
   localparam logic [OPCODE_BITS-1:0]   OP_LOOP = OPCODE_BITS'(7);
   localparam logic [FUNCTION_BITS-1:0] FN_LOOP = '0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] ISSUE = 2'd2;

   logic [1:0]            r_state;
   logic [ITER_BITS-1:0]  r_iterCount;
   logic [ITER_BITS-1:0]  r_iter;
   logic [PTR_BITS-1:0]   r_lastIdx;
   logic [PTR_BITS-1:0]   r_wrPtr;
   logic [PTR_BITS-1:0]   r_rdPtr;
   logic                  r_loopErr;
   logic [INST_WIDTH-1:0] r_outInst;
   logic                  r_outValid;
   logic                  r_inLoop;
   logic                  r_loopDone;
   logic [INST_WIDTH-1:0] r_buf [BODY_DEPTH];

   logic [INST_WIDTH-1:0] w_nopInst;
   logic                  w_accept;
   logic                  w_isCfg;
   logic                  w_fillLast;
   logic                  w_rdWrap;
   logic                  w_lastIssue;

   assign w_nopInst   = {OP_NOP, {(INST_WIDTH-OPCODE_BITS){1'b0}}};
   assign inst_ready  = reset && (r_state != ISSUE);
   assign busy        = (r_state != IDLE);
   assign w_accept    = inst_valid && inst_ready;
   assign w_isCfg     = (inst_in[OP_LSB +: OPCODE_BITS] == OP_LOOP) &&
                        (inst_in[FN_LSB +: FUNCTION_BITS] == FN_LOOP);
   assign w_fillLast  = (r_state == FILL) && w_accept && (r_wrPtr == r_lastIdx);
   assign w_rdWrap    = (r_rdPtr == r_lastIdx);
   assign w_lastIssue = (r_state == ISSUE) && w_rdWrap &&
                        (r_iter == r_iterCount - ITER_BITS'(1));

   // A body-length field of 0 wraps to the last buffer index, i.e. a full-depth body.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_iterCount <= '0;
         r_iter      <= '0;
         r_lastIdx   <= '0;
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_loopErr   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept && w_isCfg) begin
                  r_iterCount <= inst_in[ITER_BITS-1:0];
                  r_lastIdx   <= inst_in[DEST_IDX_LSB +: NS_INDEX_ID_BITS] - PTR_BITS'(1);
                  r_wrPtr     <= '0;
                  r_state     <= FILL;
               end
            end
            FILL: begin
               if (w_accept) begin
                  r_wrPtr <= r_wrPtr + PTR_BITS'(1);
                  if (w_isCfg) begin
                     r_loopErr <= 1'b1;
                  end
                  if (w_fillLast) begin
                     r_rdPtr <= '0;
                     r_iter  <= '0;
                     r_state <= (r_iterCount != '0) ? ISSUE : IDLE;
                  end
               end
            end
            ISSUE: begin
               r_rdPtr <= w_rdWrap ? '0 : r_rdPtr + PTR_BITS'(1);
               if (w_rdWrap) begin
                  r_iter <= r_iter + ITER_BITS'(1);
               end
               if (w_lastIssue) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Body storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if ((r_state == FILL) && w_accept) begin
         r_buf[r_wrPtr] <= w_isCfg ? w_nopInst : inst_in;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_outInst  <= w_nopInst;
         r_outValid <= 1'b0;
         r_inLoop   <= 1'b0;
         r_loopDone <= 1'b0;
      end else begin
         r_outInst  <= w_nopInst;
         r_outValid <= 1'b0;
         r_inLoop   <= 1'b0;
         r_loopDone <= 1'b0;
         if ((r_state == IDLE) && w_accept && !w_isCfg) begin
            r_outInst  <= inst_in;
            r_outValid <= 1'b1;
         end else if (r_state == ISSUE) begin
            r_outInst  <= r_buf[r_rdPtr];
            r_outValid <= 1'b1;
            r_inLoop   <= 1'b1;
            r_loopDone <= w_lastIssue;
         end
      end
   end

   assign opcode           = r_outInst[OP_LSB +: OPCODE_BITS];
   assign fn               = r_outInst[FN_LSB +: FUNCTION_BITS];
   assign dest_ns_id       = r_outInst[DEST_ID_LSB +: NS_ID_BITS];
   assign dest_ns_index_id = r_outInst[DEST_IDX_LSB +: NS_INDEX_ID_BITS];
   assign src1_ns_id       = r_outInst[SRC1_ID_LSB +: NS_ID_BITS];
   assign src1_ns_index_id = r_outInst[SRC1_IDX_LSB +: NS_INDEX_ID_BITS];
   assign src2_ns_id       = r_outInst[SRC2_ID_LSB +: NS_ID_BITS];
   assign src2_ns_index_id = r_outInst[SRC2_IDX_LSB +: NS_INDEX_ID_BITS];
   assign in_loop          = r_inLoop;
   assign out_valid        = r_outValid;
   assign loop_done        = r_loopDone;
   assign loop_err         = r_loopErr;

endmodule

// File: tb/tb_simd_loop_sequencer.sv
// Directed bench for simd_loop_sequencer: table-driven passthrough/loop vectors
// plus hand-written full-depth and reset-during-replay sequences.
module tb_simd_loop_sequencer;

   localparam logic [31:0] NOP = 32'hF000_0000;

   typedef struct {
      logic [31:0] inst;
      logic        valid;
      logic [31:0] expInst;
      logic        expValid;
      logic        expInLoop;
      logic        expDone;
      logic        expBusy;
      logic        expReady;
      logic        expErr;
   } vec_t;

   logic        clk;
   logic        reset;
   logic [31:0] inst_in;
   logic        inst_valid;
   logic        inst_ready;
   logic [3:0]  opcode;
   logic [3:0]  fn;
   logic [2:0]  dest_ns_id;
   logic [4:0]  dest_ns_index_id;
   logic [2:0]  src1_ns_id;
   logic [4:0]  src1_ns_index_id;
   logic [2:0]  src2_ns_id;
   logic [4:0]  src2_ns_index_id;
   logic        in_loop;
   logic        out_valid;
   logic        loop_done;
   logic        busy;
   logic        loop_err;

   int nChecks = 0;
   int nErrors = 0;
   vec_t vecs[$];

   simd_loop_sequencer dut (
      .clk(clk),
      .reset(reset),
      .inst_in(inst_in),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .opcode(opcode),
      .fn(fn),
      .dest_ns_id(dest_ns_id),
      .dest_ns_index_id(dest_ns_index_id),
      .src1_ns_id(src1_ns_id),
      .src1_ns_index_id(src1_ns_index_id),
      .src2_ns_id(src2_ns_id),
      .src2_ns_index_id(src2_ns_index_id),
      .in_loop(in_loop),
      .out_valid(out_valid),
      .loop_done(loop_done),
      .busy(busy),
      .loop_err(loop_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic [31:0] inst, logic valid, logic [31:0] eInst,
                               logic eV, logic eL, logic eD, logic eB, logic eR, logic eE);
      vec_t v;
      v.inst = inst; v.valid = valid; v.expInst = eInst; v.expValid = eV;
      v.expInLoop = eL; v.expDone = eD; v.expBusy = eB; v.expReady = eR; v.expErr = eE;
      return v;
   endfunction

   task automatic applyStimulus(input logic [31:0] inst, input logic valid);
      inst_in    = inst;
      inst_valid = valid;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] eInst, input logic eV,
                              input logic eL, input logic eD, input logic eB,
                              input logic eR, input logic eE);
      logic [31:0] gotInst;
      gotInst = {opcode, fn, dest_ns_id, dest_ns_index_id, src1_ns_id, src1_ns_index_id,
                 src2_ns_id, src2_ns_index_id};
      nChecks++;
      if ({gotInst, out_valid, in_loop, loop_done, busy, inst_ready, loop_err} !==
          {eInst, eV, eL, eD, eB, eR, eE}) begin
         nErrors++;
         $display("[TB] FAIL %s: got inst=%h v=%b loop=%b done=%b busy=%b rdy=%b err=%b, expected inst=%h v=%b loop=%b done=%b busy=%b rdy=%b err=%b",
                  name, gotInst, out_valid, in_loop, loop_done, busy, inst_ready, loop_err,
                  eInst, eV, eL, eD, eB, eR, eE);
      end
   endtask

   initial begin
      // Fields: inst, valid, expInst, expValid, expInLoop, expDone, expBusy, expReady, expErr
      vecs.push_back(mk(32'h0A23_4567, 1, 32'h0A23_4567, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(32'h0000_0000, 0, NOP,           0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(32'h5BCD_EF12, 1, 32'h5BCD_EF12, 1, 0, 0, 0, 1, 0));
      vecs.push_back(mk(32'h7100_0003, 1, 32'h7100_0003, 1, 0, 0, 0, 1, 0));
      // Basic loop: body_len=2, iter_count=3, body A,B
      vecs.push_back(mk(32'h7002_0003, 1, NOP,           0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(32'h1111_2222, 1, NOP,           0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(32'h2233_4455, 1, NOP,           0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0000, 0, 32'h1111_2222, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0000, 0, 32'h2233_4455, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0000, 0, 32'h1111_2222, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0000, 0, 32'h2233_4455, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0000, 0, 32'h1111_2222, 1, 1, 0, 1, 0, 0));
      vecs.push_back(mk(32'h0000_0000, 0, 32'h2233_4455, 1, 1, 1, 0, 1, 0));
      vecs.push_back(mk(32'h3C3C_1234, 1, 32'h3C3C_1234, 1, 0, 0, 0, 1, 0));
      // Zero iterations: body_len=1, iter_count=0
      vecs.push_back(mk(32'h7001_0000, 1, NOP,           0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(32'h4444_5555, 1, NOP,           0, 0, 0, 0, 1, 0));
      vecs.push_back(mk(32'h6A6A_0101, 1, 32'h6A6A_0101, 1, 0, 0, 0, 1, 0));
      // Nested config: body_len=2, iter_count=1, body {LOOP_CONFIG, D}
      vecs.push_back(mk(32'h7002_0001, 1, NOP,           0, 0, 0, 1, 1, 0));
      vecs.push_back(mk(32'h7005_0009, 1, NOP,           0, 0, 0, 1, 1, 1));
      vecs.push_back(mk(32'h8765_4321, 1, NOP,           0, 0, 0, 1, 0, 1));
      vecs.push_back(mk(32'h0000_0000, 0, NOP,           1, 1, 0, 1, 0, 1));
      vecs.push_back(mk(32'h0000_0000, 0, 32'h8765_4321, 1, 1, 1, 0, 1, 1));
      vecs.push_back(mk(32'h0000_0000, 0, NOP,           0, 0, 0, 0, 1, 1));

      reset = 1'b1;
      applyStimulus(32'h0, 1'b0);
      #2 reset = 1'b0;
      #2 checkOutput("reset_t0", NOP, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      checkOutput("reset_held", NOP, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1 checkOutput("idle_after_reset", NOP, 0, 0, 0, 0, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].inst, vecs[i].valid);
         @(negedge clk);
         checkOutput($sformatf("vec%0d", i), vecs[i].expInst, vecs[i].expValid,
                     vecs[i].expInLoop, vecs[i].expDone, vecs[i].expBusy,
                     vecs[i].expReady, vecs[i].expErr);
      end

      // Full depth: body_len field 0 (32 entries), iter_count=2
      applyStimulus(32'h7000_0002, 1'b1);
      @(negedge clk);
      checkOutput("full_cfg", NOP, 0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(32'h9000_0000 | 32'(i), 1'b1);
         @(negedge clk);
      end
      checkOutput("full_filled", NOP, 0, 0, 0, 1, 0, 1);
      applyStimulus(32'h0, 1'b0);
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         checkOutput($sformatf("full_rep%0d", k), 32'h9000_0000 | 32'(k % 32), 1, 1,
                     (k == 63), (k != 63), (k == 63), 1);
      end
      @(negedge clk);
      checkOutput("full_after", NOP, 0, 0, 0, 0, 1, 1);

      // Reset during the third replay of a 2x4 loop
      reset = 1'b0;
      #1 checkOutput("clear_err", NOP, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(32'h7002_0004, 1'b1);
      @(negedge clk);
      applyStimulus(32'hABCD_0001, 1'b1);
      @(negedge clk);
      applyStimulus(32'hABCD_0002, 1'b1);
      @(negedge clk);
      checkOutput("rst_fill_done", NOP, 0, 0, 0, 1, 0, 0);
      applyStimulus(32'h0, 1'b0);
      @(negedge clk);
      checkOutput("rst_rep1", 32'hABCD_0001, 1, 1, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("rst_rep2", 32'hABCD_0002, 1, 1, 0, 1, 0, 0);
      @(negedge clk);
      checkOutput("rst_rep3", 32'hABCD_0001, 1, 1, 0, 1, 0, 0);
      #2 reset = 1'b0;
      #1 checkOutput("rst_async", NOP, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("rst_after%0d", k), NOP, 0, 0, 0, 0, 1, 0);
      end
      applyStimulus(32'h2468_ACE0, 1'b1);
      @(negedge clk);
      checkOutput("rst_passthru", 32'h2468_ACE0, 1, 0, 0, 0, 1, 0);
      applyStimulus(32'h0, 1'b0);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
